bloke2_msg_packer: RTL
======================

Name: bloke2_msg_packer

Overview:
Parametrised message front-end for the BLAKE2 hash cores. It accepts a byte stream (1, 2 or 4 bytes per beat) delimited by start/finish and packs it into little-endian message blocks. Each block carries the BLAKE2 byte counter t and last-block flag. Sits between the streaming byte interface and the compression engine; zero-pads the final block and handles the empty-message case.

Parameters:
DIN_BYTES, 1, bytes per input beat; legal values 1, 2, 4.
BLOCK_BYTES, 64, bytes per message block (64 for BLAKE2s, 128 for BLAKE2b); must be a multiple of DIN_BYTES.
CNT_W, 64, width of byte counter t (64 for BLAKE2s, 128 for BLAKE2b).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a new message and aborts any message in progress.
finish  in  1  one-cycle pulse; marks the end of the message.
din  in  8*DIN_BYTES  input bytes; lane 0 (din[7:0]) is the earliest byte.
din_nbytes  in  $clog2(DIN_BYTES+1)  valid lanes in this beat, filled from lane 0; values 1..DIN_BYTES; less than DIN_BYTES only on the final beat.
din_valid  in  1  input beat valid.
din_ready  out  1  input beat accepted when din_valid && din_ready.
blk_data  out  8*BLOCK_BYTES  block; message byte k of the block at bits [8k +: 8].
blk_count  out  CNT_W  total message bytes up to and including this block (BLAKE2 t).
blk_last  out  1  final block of the message.
blk_valid  out  1  block valid; held with data stable until blk_ready.
blk_ready  in  1  consumer accepts the block.

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE; din_ready=0, blk_valid=0, blk_last=0, blk_count=0, blk_data=0; fill pointer and byte counter cleared.
- States: IDLE, FILL, EMIT, DONE.
- Priority: rst > start > everything else. start in any state: clears buffer, fill pointer, counter and pending-finish; drops blk_valid; next state FILL.
- IDLE: waits for start; din_ready=0.
- FILL: din_ready = !full. Here full means fill pointer == BLOCK_BYTES.
  - On an accepted beat: write din_nbytes lanes at the fill pointer, advance the pointer, and add din_nbytes to the counter.
- Deferred emission rule: a full block is never emitted on filling alone. BLAKE2 needs to know whether more data follows.
  - full && din_valid: emit with last=0. The beat is not accepted this cycle.
  - full && finish: emit with last=1.
  - partial buffer (including 0 bytes) && finish: zero-pad the remaining bytes and emit with last=1.
  - Empty message (start then finish): one all-zero block, count=0, last=1.
- finish and an accepted beat in the same cycle: the beat is included, then finish is applied. If that beat fills the block, the block is emitted with last=1.
- EMIT: blk_valid=1 from the cycle after the triggering edge. blk_data, blk_count and blk_last stay stable until blk_valid && blk_ready.
  - On handshake with last=0: clear buffer and pointer, keep the counter, return to FILL.
  - On handshake with last=1: go to DONE.
- finish arriving during EMIT (last=0) is latched as pending. After the handshake the buffer is empty, so an empty final block would be wrong. Instead, a pending finish with last=0 re-marks the emitted block.
  - Implementation rule: in FILL with a full buffer, no emission occurs until din_valid or finish is seen. This makes the last=0 + finish race impossible by construction; the bench must still check it.
- DONE: din_ready=0, blk_valid=0; finish ignored; waits for start.
- din_valid outside FILL is ignored. finish in IDLE or DONE is ignored.
- Counter width: the counter wraps modulo 2^CNT_W with no saturation.
- din_nbytes=0 or din_nbytes>DIN_BYTES is illegal; behaviour is undefined and the bench asserts the input never occurs.

Test Plan:
- DIN_BYTES=1; start, finish, no data -> one block: blk_data=0, blk_count=0, blk_last=1. Then DONE, din_ready=0.
- DIN_BYTES=1; "abc" -> blk_data[23:0]=24'h636261, upper bits 0, blk_count=3, blk_last=1, exactly one block.
- DIN_BYTES=1; 64 bytes 0x00..0x3F then finish -> no blk_valid before finish. One block: byte k = k, blk_count=64, blk_last=1.
- DIN_BYTES=1; 65 bytes 0x00..0x40 -> block 1: count=64, last=0, issued only when byte 65 is presented. Block 2: byte0=0x40, rest 0, count=65, last=1.
- DIN_BYTES=4; beats 32'h64636261 (nbytes=4) and 32'h00006665 (nbytes=2), then finish -> blk_data[47:0]=48'h666564636261, count=6, last=1.
- blk_ready held low 5 cycles during EMIT, then start mid-second-message after 10 bytes -> block data stable for all 5 cycles. After start: blk_valid=0, counter restarts, and the next message hashes "abc" with count=3.

Source files
------------

// File: rtl/bloke2_msg_packer.sv
// bloke2_msg_packer
// -----------------
// Byte-stream front-end for the BLAKE2 compression engines. Packs 1/2/4-byte
// beats into little-endian message blocks, tracks the BLAKE2 byte counter t,
// flags the final block and zero-pads it. An empty message yields one all-zero
// block with t=0 and last=1.
//
// A full block is held back until the producer shows what comes next: more
// data (block is not the last) or finish (block is the last).
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start                pulse: begin a new message, abort any in progress
//   finish               pulse: end of message
//   din / din_nbytes     input beat, lane 0 earliest, lanes filled from 0
//   din_valid/din_ready  input handshake
//   blk_data             block, message byte k at [8k +: 8]
//   blk_count            message bytes up to and including this block
//   blk_last             final block of the message
//   blk_valid/blk_ready  output handshake, block held stable while stalled
module bloke2_msg_packer #(
  parameter int DIN_BYTES   = 1,
  parameter int BLOCK_BYTES = 64,
  parameter int CNT_W       = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             finish,
  input  logic [8*DIN_BYTES-1:0]           din,
  input  logic [$clog2(DIN_BYTES+1)-1:0]   din_nbytes,
  input  logic                             din_valid,
  output logic                             din_ready,
  output logic [8*BLOCK_BYTES-1:0]         blk_data,
  output logic [CNT_W-1:0]                 blk_count,
  output logic                             blk_last,
  output logic                             blk_valid,
  input  logic                             blk_ready
);

  localparam int PTR_W = $clog2(BLOCK_BYTES + 1);
  localparam int BIT_W = $clog2(8 * BLOCK_BYTES);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

  state_t                   state_q, state_d;
  logic [8*BLOCK_BYTES-1:0] buf_q, buf_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     last_q, last_d;
  logic                     din_ready_q, din_ready_d;
  logic                     blk_valid_q, blk_valid_d;

  logic                     full;
  logic                     accept;
  logic [BIT_W-1:0]         bit_idx;

  assign full   = (ptr_q == PTR_W'(BLOCK_BYTES));
  assign accept = din_valid && din_ready_q;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    bit_idx = '0;

    if (start) begin
      state_d = FILL;
      buf_d   = '0;
      ptr_d   = '0;
      cnt_d   = '0;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            for (int i = 0; i < DIN_BYTES; i++) begin
              if (i < int'(din_nbytes) && int'(ptr_q) + i < BLOCK_BYTES) begin
                bit_idx = BIT_W'((int'(ptr_q) + i) * 8);
                buf_d[bit_idx +: 8] = din[8*i +: 8];
              end
            end
            ptr_d = ptr_q + PTR_W'(din_nbytes);
            cnt_d = cnt_q + CNT_W'(din_nbytes);
          end
          // Bytes beyond the fill pointer are already zero, so emitting the
          // buffer as-is gives the padded final block.
          if (finish) begin
            state_d = EMIT;
            last_d  = 1'b1;
          end else if (full && din_valid) begin
            state_d = EMIT;
            last_d  = 1'b0;
          end
        end
        EMIT: begin
          if (blk_ready) begin
            // A finish coinciding with the handshake ends the message here:
            // the following block would otherwise be an empty final block.
            if (last_q || finish) begin
              state_d = DONE;
            end else begin
              state_d = FILL;
              buf_d   = '0;
              ptr_d   = '0;
            end
          end else if (finish) begin
            // Late finish re-marks the held block as the final one.
            last_d = 1'b1;
          end
        end
        default: ;  // IDLE and DONE wait for start
      endcase
    end

    din_ready_d = (state_d == FILL) && (ptr_d != PTR_W'(BLOCK_BYTES));
    blk_valid_d = (state_d == EMIT);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      // NOTE: the block buffer is reset because it drives blk_data directly
      // and zero padding relies on unwritten bytes being cleared.
      buf_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      din_ready_q <= 1'b0;
      blk_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      din_ready_q <= din_ready_d;
      blk_valid_q <= blk_valid_d;
    end
  end

  assign din_ready = din_ready_q;
  assign blk_data  = buf_q;
  assign blk_count = cnt_q;
  assign blk_last  = last_q;
  assign blk_valid = blk_valid_q;

endmodule
